// File: rtl/hdmi_timing_pkg.sv
// CEA-861-D raster timing table and helpers shared by the timing generator.
// Horizontal/vertical sync start values are offsets from the end of the active area.
package hdmi_timing_pkg;

  typedef struct packed {
    logic [15:0] fw;
    logic [15:0] fh;
    logic [15:0] sw;
    logic [15:0] sh;
    logic [15:0] hs_start;
    logic [15:0] hs_size;
    logic [15:0] vs_start;
    logic [15:0] vs_size;
    logic        invert;
  } timing_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } req_state_e;

  localparam timing_t T_VIC1 = '{fw: 16'd800,  fh: 16'd525,  sw: 16'd640,  sh: 16'd480,
                                 hs_start: 16'd16,  hs_size: 16'd96, vs_start: 16'd10,
                                 vs_size: 16'd2,  invert: 1'b1};
  localparam timing_t T_VIC2 = '{fw: 16'd858,  fh: 16'd525,  sw: 16'd720,  sh: 16'd480,
                                 hs_start: 16'd16,  hs_size: 16'd62, vs_start: 16'd9,
                                 vs_size: 16'd6,  invert: 1'b1};
  localparam timing_t T_VIC4 = '{fw: 16'd1650, fh: 16'd750,  sw: 16'd1280, sh: 16'd720,
                                 hs_start: 16'd110, hs_size: 16'd40, vs_start: 16'd5,
                                 vs_size: 16'd5,  invert: 1'b0};
  localparam timing_t T_VIC16 = '{fw: 16'd2200, fh: 16'd1125, sw: 16'd1920, sh: 16'd1080,
                                  hs_start: 16'd88,  hs_size: 16'd44, vs_start: 16'd4,
                                  vs_size: 16'd5,  invert: 1'b0};
  localparam timing_t T_VIC17 = '{fw: 16'd864,  fh: 16'd625,  sw: 16'd720,  sh: 16'd576,
                                  hs_start: 16'd12,  hs_size: 16'd64, vs_start: 16'd5,
                                  vs_size: 16'd5,  invert: 1'b1};
  localparam timing_t T_VIC19 = '{fw: 16'd1980, fh: 16'd750,  sw: 16'd1280, sh: 16'd720,
                                  hs_start: 16'd440, hs_size: 16'd40, vs_start: 16'd5,
                                  vs_size: 16'd5,  invert: 1'b0};
  localparam timing_t T_VIC95 = '{fw: 16'd4400, fh: 16'd2250, sw: 16'd3840, sh: 16'd2160,
                                  hs_start: 16'd176, hs_size: 16'd88, vs_start: 16'd8,
                                  vs_size: 16'd10, invert: 1'b0};

  function automatic logic vic_supported(input logic [7:0] vic);
    case (vic)
      8'd1, 8'd2, 8'd3, 8'd4, 8'd16, 8'd34, 8'd17, 8'd18, 8'd19,
      8'd95, 8'd97, 8'd105, 8'd107: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Unsupported codes map to VIC 1 so the table is total; callers gate on vic_supported.
  function automatic timing_t vic_timing(input logic [7:0] vic);
    case (vic)
      8'd2, 8'd3:                     return T_VIC2;
      8'd4:                           return T_VIC4;
      8'd16, 8'd34:                   return T_VIC16;
      8'd17, 8'd18:                   return T_VIC17;
      8'd19:                          return T_VIC19;
      8'd95, 8'd97, 8'd105, 8'd107:   return T_VIC95;
      default:                        return T_VIC1;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_vic_timing_rom.sv
// Combinational VIC lookup: timing parameters plus a supported flag.
module hdmi_vic_timing_rom
  import hdmi_timing_pkg::*;
(
  input  logic [7:0] i_vic,
  output timing_t    o_tim,
  output logic       o_supported
);

  always_comb begin
    o_tim       = vic_timing(i_vic);
    o_supported = vic_supported(i_vic);
  end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Runtime-programmable CEA-861 raster generator with mode switching taken at the frame wrap.
module hdmi_video_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int BIT_WIDTH   = 13,
  parameter int BIT_HEIGHT  = 12,
  parameter int DEFAULT_VIC = 1,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic                  mode_req,
  input  logic [7:0]            vic_sel,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  mode_pending,
  output logic                  mode_err,
  output logic [7:0]            active_vic,
  output logic [BIT_WIDTH-1:0]  frame_width,
  output logic [BIT_HEIGHT-1:0] frame_height,
  output logic [BIT_WIDTH-1:0]  screen_width,
  output logic [BIT_HEIGHT-1:0] screen_height
);

  localparam int CW = ((BIT_WIDTH > BIT_HEIGHT) ? BIT_WIDTH : BIT_HEIGHT) + 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } dec_t;

  function automatic dec_t f_decode(input logic [BIT_WIDTH-1:0]  x,
                                    input logic [BIT_HEIGHT-1:0] y,
                                    input timing_t               t);
    logic [CW-1:0] xx, yy, h0, h1, v0, v1;
    dec_t d;
    xx   = CW'(x);
    yy   = CW'(y);
    h0   = CW'(t.sw) + CW'(t.hs_start);
    h1   = h0 + CW'(t.hs_size);
    v0   = CW'(t.sh) + CW'(t.vs_start);
    v1   = v0 + CW'(t.vs_size);
    d.hs = t.invert ^ ((xx >= h0) && (xx < h1));
    d.vs = t.invert ^ ((yy >= v0) && (yy < v1));
    d.de = (xx < CW'(t.sw)) && (yy < CW'(t.sh));
    d.ls = (x == '0);
    d.fs = (x == '0) && (y == '0);
    return d;
  endfunction

  localparam timing_t RST_TIM = vic_timing(8'(DEFAULT_VIC));
  localparam dec_t    RST_DEC = f_decode(BIT_WIDTH'(START_X), BIT_HEIGHT'(START_Y), RST_TIM);

  req_state_e            r_state, w_state_nx;
  logic [BIT_WIDTH-1:0]  r_cx, w_nx_cx;
  logic [BIT_HEIGHT-1:0] r_cy, w_nx_cy;
  timing_t               r_tim, r_pend_tim, w_nx_tim, w_sel_tim;
  logic [7:0]            r_active_vic, r_pend_vic;
  logic                  r_err;
  dec_t                  r_dec, w_nx_dec;
  logic                  w_sel_sup, w_req_ok, w_end_x, w_end_y, w_wrap, w_load, w_switch;

  hdmi_vic_timing_rom u_rom_sel (
    .i_vic       (vic_sel),
    .o_tim       (w_sel_tim),
    .o_supported (w_sel_sup)
  );

  always_comb begin
    w_end_x  = (CW'(r_cx) + CW'(1)) == CW'(r_tim.fw);
    w_end_y  = (CW'(r_cy) + CW'(1)) == CW'(r_tim.fh);
    w_wrap   = w_end_x && w_end_y;
    w_req_ok = mode_req && w_sel_sup;
  end

  // A valid request in the wrap cycle suppresses that wrap's switch and waits a full frame.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_switch   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_ok) begin
          w_load     = 1'b1;
          w_state_nx = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_req_ok) begin
          w_load = 1'b1;
        end else if (w_wrap) begin
          w_switch   = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Decode is taken from the next-cycle position and timing so it lands with cx/cy, no skew.
  always_comb begin
    w_nx_tim = w_switch ? r_pend_tim : r_tim;
    w_nx_cx  = w_end_x ? '0 : r_cx + 1'b1;
    w_nx_cy  = r_cy;
    if (w_end_x) w_nx_cy = w_end_y ? '0 : r_cy + 1'b1;
    w_nx_dec = f_decode(w_nx_cx, w_nx_cy, w_nx_tim);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_cx         <= BIT_WIDTH'(START_X);
      r_cy         <= BIT_HEIGHT'(START_Y);
      r_tim        <= RST_TIM;
      r_pend_tim   <= RST_TIM;
      r_active_vic <= 8'(DEFAULT_VIC);
      r_pend_vic   <= 8'(DEFAULT_VIC);
      r_err        <= 1'b0;
      r_dec        <= RST_DEC;
    end else begin
      r_cx  <= w_nx_cx;
      r_cy  <= w_nx_cy;
      r_tim <= w_nx_tim;
      r_err <= mode_req && !w_sel_sup;
      r_dec <= w_nx_dec;
      if (w_load) begin
        r_pend_vic <= vic_sel;
        r_pend_tim <= w_sel_tim;
      end
      if (w_switch) r_active_vic <= r_pend_vic;
    end
  end

  assign cx            = r_cx;
  assign cy            = r_cy;
  assign hsync         = r_dec.hs;
  assign vsync         = r_dec.vs;
  assign de            = r_dec.de;
  assign line_start    = r_dec.ls;
  assign frame_start   = r_dec.fs;
  assign mode_pending  = (r_state == ST_PENDING);
  assign mode_err      = r_err;
  assign active_vic    = r_active_vic;
  assign frame_width   = BIT_WIDTH'(r_tim.fw);
  assign frame_height  = BIT_HEIGHT'(r_tim.fh);
  assign screen_width  = BIT_WIDTH'(r_tim.sw);
  assign screen_height = BIT_HEIGHT'(r_tim.sh);

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Randomized bench for hdmi_video_timing_gen against a raster model built from CEA-861-D rules.
// START_Y sits near the frame end so frame wraps are reached in a short run.
module tb_hdmi_video_timing_gen;

  localparam int SY = 489;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic        mode_req;
  logic [7:0]  vic_sel;
  logic [12:0] cx, frame_width, screen_width;
  logic [11:0] cy, frame_height, screen_height;
  logic        hsync, vsync, de, line_start, frame_start, mode_pending, mode_err;
  logic [7:0]  active_vic;

  hdmi_video_timing_gen #(
    .BIT_WIDTH   (13),
    .BIT_HEIGHT  (12),
    .DEFAULT_VIC (1),
    .START_X     (0),
    .START_Y     (SY)
  ) dut (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .mode_req      (mode_req),
    .vic_sel       (vic_sel),
    .cx            (cx),
    .cy            (cy),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .mode_pending  (mode_pending),
    .mode_err      (mode_err),
    .active_vic    (active_vic),
    .frame_width   (frame_width),
    .frame_height  (frame_height),
    .screen_width  (screen_width),
    .screen_height (screen_height)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int fw, fh, sw, sh, hfp, hs, vfp, vs;
    bit inv;
  } tt_t;

  // Totals, active sizes, front porches, sync widths and polarity per VIC; fw==0 means unsupported.
  function automatic tt_t tt(input int v);
    case (v)
      1:                  return '{800, 525, 640, 480, 16, 96, 10, 2, 1'b1};
      2, 3:               return '{858, 525, 720, 480, 16, 62, 9, 6, 1'b1};
      4:                  return '{1650, 750, 1280, 720, 110, 40, 5, 5, 1'b0};
      16, 34:             return '{2200, 1125, 1920, 1080, 88, 44, 4, 5, 1'b0};
      17, 18:             return '{864, 625, 720, 576, 12, 64, 5, 5, 1'b1};
      19:                 return '{1980, 750, 1280, 720, 440, 40, 5, 5, 1'b0};
      95, 97, 105, 107:   return '{4400, 2250, 3840, 2160, 176, 88, 8, 10, 1'b0};
      default:            return '{0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
    endcase
  endfunction

  int total = 0;
  int bad   = 0;
  int mx, my, mv, mpv;
  bit mp, merr;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = SY; mv = 1; mpv = 1; mp = 0; merr = 0;
  endtask

  task automatic model_clock(input bit req, input int sel);
    tt_t t;
    bit  wrap, ok;
    t    = tt(mv);
    ok   = req && (tt(sel).fw != 0);
    wrap = (mx == t.fw - 1) && (my == t.fh - 1);
    merr = req && !ok;
    if (ok) begin
      mp = 1; mpv = sel;
    end else if (wrap && mp) begin
      mv = mpv; mp = 0;
    end
    if (mx == t.fw - 1) begin
      mx = 0;
      my = (my == t.fh - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic check_all();
    tt_t t;
    int hs0, vs0;
    t   = tt(mv);
    hs0 = t.sw + t.hfp;
    vs0 = t.sh + t.vfp;
    chk("cx", int'(cx), mx);
    chk("cy", int'(cy), my);
    chk("de", int'(de), int'(mx < t.sw && my < t.sh));
    chk("hsync", int'(hsync), int'(t.inv ^ (mx >= hs0 && mx < hs0 + t.hs)));
    chk("vsync", int'(vsync), int'(t.inv ^ (my >= vs0 && my < vs0 + t.vs)));
    chk("line_start", int'(line_start), int'(mx == 0));
    chk("frame_start", int'(frame_start), int'(mx == 0 && my == 0));
    chk("mode_pending", int'(mode_pending), int'(mp));
    chk("mode_err", int'(mode_err), int'(merr));
    chk("active_vic", int'(active_vic), mv);
    chk("frame_width", int'(frame_width), t.fw);
    chk("frame_height", int'(frame_height), t.fh);
    chk("screen_width", int'(screen_width), t.sw);
    chk("screen_height", int'(screen_height), t.sh);
  endtask

  // Called at a falling edge: drive, clock, advance the model, compare at the next falling edge.
  task automatic step(input bit req, input int sel);
    mode_req = req;
    vic_sel  = sel[7:0];
    @(posedge clk_pixel);
    model_clock(req, sel);
    @(negedge clk_pixel);
    mode_req = 1'b0;
    check_all();
  endtask

  function automatic int rnd_vic();
    int pool[18] = '{1, 2, 3, 4, 16, 34, 17, 18, 19, 95, 97, 105, 107, 0, 5, 200, 255, 106};
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 255));
    return pool[$urandom_range(0, 17)];
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vs_low, de_cnt, hs_cnt, hs_first, hs_last, n;

    reset = 1'b1; mode_req = 1'b0; vic_sel = '0;
    #12;
    model_reset();
    check_all();
    chk("rst_cx_lit", int'(cx), 0);
    chk("rst_cy_lit", int'(cy), SY);
    chk("rst_de_lit", int'(de), 0);
    chk("rst_hsync_lit", int'(hsync), 1);
    chk("rst_vsync_lit", int'(vsync), 1);
    chk("rst_line_start_lit", int'(line_start), 1);
    chk("rst_frame_start_lit", int'(frame_start), 0);
    chk("rst_fw_lit", int'(frame_width), 800);
    @(negedge clk_pixel);
    reset = 1'b0;

    // Unsupported VIC: single error pulse, nothing pending
    step(1'b1, 200);
    chk("err_pulse_lit", int'(mode_err), 1);
    chk("err_pend_lit", int'(mode_pending), 0);
    step(1'b0, 0);
    chk("err_clear_lit", int'(mode_err), 0);

    // Random requests up to the frame wrap; vsync must be low for lines 490..491 only
    vs_low = 0;
    for (n = 0; n < 30000 && !(mx == 799 && my == 524); n++) begin
      if (!vsync) vs_low++;
      step($urandom_range(0, 63) == 0, rnd_vic());
    end
    chk("wrap1_cx_lit", int'(cx), 799);
    chk("wrap1_cy_lit", int'(cy), 524);
    chk("vsync_low_cycles", vs_low, 1600);

    // Request on the wrap cycle itself is held for the following frame
    step(1'b1, 16);
    chk("wrapreq_cx_lit", int'(cx), 0);
    chk("wrapreq_cy_lit", int'(cy), 0);
    chk("wrapreq_vic_lit", int'(active_vic), 1);
    chk("wrapreq_pend_lit", int'(mode_pending), 1);
    chk("wrapreq_fs_lit", int'(frame_start), 1);
    chk("wrapreq_de_lit", int'(de), 1);

    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 800; i++) begin
      if (de) de_cnt++;
      if (!hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(cx);
        hs_last = int'(cx);
      end
      step(1'b0, 0);
    end
    chk("vic1_de_per_line", de_cnt, 640);
    chk("vic1_hs_cycles", hs_cnt, 96);
    chk("vic1_hs_first", hs_first, 656);
    chk("vic1_hs_last", hs_last, 751);

    // Reset mid-line with a request pending
    for (int i = 0; i < 300; i++) step(1'b0, 0);
    chk("pre_rst_pend_lit", int'(mode_pending), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("midrst_pend_lit", int'(mode_pending), 0);
    chk("midrst_cx_lit", int'(cx), 0);
    chk("midrst_vic_lit", int'(active_vic), 1);
    @(negedge clk_pixel);
    check_all();
    reset = 1'b0;

    // Switch to VIC 4 taken at the wrap
    for (n = 0; n < 10000 && !(mx == 0 && my == 500); n++) step(1'b0, 0);
    step(1'b1, 4);
    chk("vic4_pend_lit", int'(mode_pending), 1);
    for (n = 0; n < 30000 && !(mx == 799 && my == 524); n++) step(1'b0, 0);
    chk("wrap2_cx_lit", int'(cx), 799);
    chk("wrap2_cy_lit", int'(cy), 524);
    step(1'b0, 0);
    chk("vic4_cx_lit", int'(cx), 0);
    chk("vic4_cy_lit", int'(cy), 0);
    chk("vic4_vic_lit", int'(active_vic), 4);
    chk("vic4_fw_lit", int'(frame_width), 1650);
    chk("vic4_pend_clr_lit", int'(mode_pending), 0);
    chk("vic4_hsync_lit", int'(hsync), 0);

    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 1650; i++) begin
      if (de) de_cnt++;
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(cx);
        hs_last = int'(cx);
      end
      step(1'b0, 0);
    end
    chk("vic4_de_per_line", de_cnt, 1280);
    chk("vic4_hs_cycles", hs_cnt, 40);
    chk("vic4_hs_first", hs_first, 1390);
    chk("vic4_hs_last", hs_last, 1429);

    for (int i = 0; i < 2000; i++) step($urandom_range(0, 7) == 0, rnd_vic());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
